fifo_load_ctrl: RTL

//  Controller for one DEPTH-entry shift-delay FIFO (d/en in, q = oldest entry out).

---
 rtl/fifo_load_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/fifo_load_ctrl.sv
// Load/drain controller for a DEPTH-entry shift-delay FIFO. Load and drain words move with zero
// latency (fifo_en in the handshake cycle). Ready and valid are pure state decodes.
module fifo_load_ctrl #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [BITS-1:0]            in_data,
  output logic                       in_ready,
  input  logic                       drain,
  output logic                       out_valid,
  output logic [BITS-1:0]            out_data,
  input  logic                       out_ready,
  output logic                       fifo_en,
  output logic [BITS-1:0]            fifo_d,
  input  logic [BITS-1:0]            fifo_q,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // clr wins over any handshake; the FIFO itself is left untouched.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    fifo_en = 1'b0;
    fifo_d  = '0;
    if (clr) begin
      state_d = LOAD;
      count_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            fifo_en = 1'b1;
            fifo_d  = in_data;
            count_d = count_q + CW'(1);
            if (count_q == CW'(DEPTH-1)) state_d = FULL;
          end
        end
        FULL: begin
          if (drain) state_d = DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            fifo_en = 1'b1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = LOAD;
          end
        end
        default: begin
          state_d = LOAD;
          count_d = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign full      = (state_q == FULL);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = fifo_q;
  assign count     = count_q;

endmodule
